// File: rtl/hcms_frame_loader.sv
// Expands a text frame through a 5x7 font ROM into dot bytes for the HCMS-29xx serializer.
// Optional power-on init (reset pulse + two control words) is enabled by HCMS_POWERON_INIT_EN.
module hcms_frame_loader #(
  parameter int unsigned NUM_CHARS    = 4,
  parameter logic [7:0]  CTRL_WORD0   = 8'h7F,
  parameter logic [7:0]  CTRL_WORD1   = 8'h81,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   r_reset,
  input  logic [8*NUM_CHARS-1:0] i_text,
  input  logic                   i_update,
  output logic                   o_busy,
  output logic [9:0]             o_font_addr,
  input  logic [7:0]             i_font_data,
  output logic [7:0]             o_byte,
  output logic                   o_byte_valid,
  input  logic                   i_byte_ready,
  output logic                   o_regsel,
  output logic                   o_last,
  output logic                   o_display_reset
);

  localparam int unsigned CHAR_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int unsigned TEXT_W = 8 * NUM_CHARS;
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(NUM_CHARS - 1);

  localparam logic [2:0] ST_IDLE    = 3'd3;
  localparam logic [2:0] ST_FETCH   = 3'd4;
  localparam logic [2:0] ST_ROMWAIT = 3'd5;
  localparam logic [2:0] ST_SEND    = 3'd6;

`ifdef HCMS_POWERON_INIT_EN
  localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [2:0] ST_RST_PULSE = 3'd0;
  localparam logic [2:0] ST_CTRL0     = 3'd1;
  localparam logic [2:0] ST_CTRL1     = 3'd2;
  localparam logic [2:0] ST_RESET     = ST_RST_PULSE;
  localparam logic       RESET_BUSY   = 1'b1;
`else
  localparam logic [2:0] ST_RESET     = ST_IDLE;
  localparam logic       RESET_BUSY   = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [TEXT_W-1:0] frame_q, frame_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [2:0]        col_q, col_d;
  logic              pending_q, pending_d;
  logic              busy_q, busy_d;
  logic [9:0]        addr_q, addr_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              regsel_q, regsel_d;
  logic              last_q, last_d;
  logic              xfer;

`ifdef HCMS_POWERON_INIT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              disp_rst_q, disp_rst_d;
  logic              unused_font;
  assign unused_font = i_font_data[7];
`else
  logic              unused_cfg;
  assign unused_cfg = ^{i_font_data[7], CTRL_WORD0, CTRL_WORD1, 32'(RESET_CYCLES)};
`endif

  assign xfer = valid_q & i_byte_ready;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      state_q    <= ST_RESET;
      frame_q    <= '0;
      char_q     <= '0;
      col_q      <= '0;
      pending_q  <= 1'b0;
      busy_q     <= RESET_BUSY;
      addr_q     <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      regsel_q   <= 1'b0;
      last_q     <= 1'b0;
`ifdef HCMS_POWERON_INIT_EN
      cnt_q      <= '0;
      disp_rst_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      char_q     <= char_d;
      col_q      <= col_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      regsel_q   <= regsel_d;
      last_q     <= last_d;
`ifdef HCMS_POWERON_INIT_EN
      cnt_q      <= cnt_d;
      disp_rst_q <= disp_rst_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    char_d    = char_q;
    col_d     = col_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    regsel_d  = regsel_q;
    last_d    = last_q;
`ifdef HCMS_POWERON_INIT_EN
    cnt_d      = cnt_q;
    disp_rst_d = disp_rst_q;
`endif

    // Requests arriving while busy collapse into one deferred frame
    if (i_update && (state_q != ST_IDLE)) pending_d = 1'b1;

    case (state_q)
`ifdef HCMS_POWERON_INIT_EN
      ST_RST_PULSE: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_CTRL0;
          disp_rst_d = 1'b0;
          byte_d     = CTRL_WORD0;
          valid_d    = 1'b1;
          regsel_d   = 1'b1;
          last_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CTRL0: begin
        if (xfer) begin
          state_d = ST_CTRL1;
          byte_d  = CTRL_WORD1;
        end
      end
      ST_CTRL1: begin
        if (xfer) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          regsel_d = 1'b0;
          last_d   = 1'b0;
        end
      end
`endif
      ST_IDLE: begin
        if (i_update || pending_q) begin
          frame_d   = i_text;
          pending_d = 1'b0;
          char_d    = '0;
          col_d     = 3'd0;
          addr_d    = {i_text[6:0], 3'd0};
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_ROMWAIT;
      ST_ROMWAIT: begin
        byte_d   = {1'b0, i_font_data[6:0]};
        valid_d  = 1'b1;
        regsel_d = 1'b0;
        last_d   = (char_q == LAST_CHAR) && (col_q == 3'd4);
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            if (col_q == 3'd4) begin
              col_d  = 3'd0;
              char_d = char_q + CHAR_W'(1);
            end else begin
              col_d = col_q + 3'd1;
            end
            addr_d  = {frame_q[8*char_d +: 7], col_d};
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_busy       = busy_q;
  assign o_font_addr  = addr_q;
  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_regsel     = regsel_q;
  assign o_last       = last_q;
`ifdef HCMS_POWERON_INIT_EN
  assign o_display_reset = disp_rst_q;
`else
  assign o_display_reset = 1'b0;
`endif

endmodule

// File: tb/tb_hcms_frame_loader.sv
// Self-checking bench for hcms_frame_loader: directed steps plus random frames against a frame-level model.
module tb_hcms_frame_loader;

  localparam int unsigned NC = 4;
  localparam int unsigned TW = 8 * NC;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       regsel;
    logic       last;
  } xfer_t;

  logic          i_clk = 1'b0;
  logic          r_reset;
  logic [TW-1:0] text;
  logic          update;
  logic          busy;
  logic [9:0]    font_addr;
  logic [7:0]    font_data;
  logic [7:0]    byte_o;
  logic          valid;
  logic          ready;
  logic          regsel;
  logic          last;
  logic          disp_rst;

  int    passed = 0;
  int    total = 0;
  int    cyc = 0;
  int    last_xfer_cyc = 0;
  int    idle_cyc = 0;
  int    ctrl_seen = 0;
  logic  rnd_ready = 1'b0;
  xfer_t mon_q[$];
  xfer_t exp_q[$];

  hcms_frame_loader #(.NUM_CHARS(NC)) dut (
    .i_clk(i_clk),
    .r_reset(r_reset),
    .i_text(text),
    .i_update(update),
    .o_busy(busy),
    .o_font_addr(font_addr),
    .i_font_data(font_data),
    .o_byte(byte_o),
    .o_byte_valid(valid),
    .i_byte_ready(ready),
    .o_regsel(regsel),
    .o_last(last),
    .o_display_reset(disp_rst)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Font ROM: one cycle latency, bit 7 set so stripping it is observable
  always @(posedge i_clk) font_data <= {1'b1, font_addr[6:0]};

  // Transfer monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (valid && ready) begin
      mon_q.push_back({font_addr, byte_o, regsel, last});
      last_xfer_cyc = cyc;
      if (regsel) ctrl_seen++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [TW-1:0] rand_text();
    logic [TW-1:0] t;
    for (int c = 0; c < NC; c++) t[8*c +: 8] = 8'($urandom);
    return t;
  endfunction

  // Reference: each character yields five column bytes, ROM data minus bit 7
  task automatic expect_frame(input logic [TW-1:0] txt);
    for (int c = 0; c < NC; c++) begin
      for (int col = 0; col < 5; col++) begin
        int    code;
        xfer_t e;
        code     = int'(txt[8*c +: 8]) % 128;
        e.addr   = 10'(code * 8 + col);
        e.data   = 8'((code * 8 + col) % 128);
        e.regsel = 1'b0;
        e.last   = (c == NC - 1) && (col == 4);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_count"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(mon_q[i]), 32'(exp_q[i]));
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    idle_cyc = cyc;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic start_frame(input logic [TW-1:0] t);
    text = t;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] t1;
    logic [7:0]    hold_b;
    logic [9:0]    hold_a;
    int            n;

    r_reset = 1'b1;
    update  = 1'b0;
    ready   = 1'b1;
    text    = '0;
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_regsel", regsel, 0);
    chk("rst_last", last, 0);
    chk("rst_addr", font_addr, 0);
`ifdef HCMS_POWERON_INIT_EN
    chk("rst_busy", busy, 1);
    chk("rst_disp", disp_rst, 1);
`else
    chk("rst_busy", busy, 0);
    chk("rst_disp", disp_rst, 0);
`endif
    tick();
    r_reset = 1'b0;

`ifdef HCMS_POWERON_INIT_EN
    n = 0;
    while (disp_rst && n < 100) begin
      n++;
      tick();
    end
    chk("init_disp_cycles", n, 16);
    chk("ctrl0_valid_first", valid, 1);
    chk("ctrl0_byte", byte_o, 8'h7F);
    wait_idle("init");
    exp_q.push_back({10'h0, 8'h7F, 1'b1, 1'b1});
    exp_q.push_back({10'h0, 8'h81, 1'b1, 1'b1});
    compare_stream("init");
`else
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (disp_rst !== 1'b0) n++;
      tick();
    end
    chk("disp_stays_low", n, 0);
`endif

    // "0123" with ready held high: latency and full stream
    start_frame("3210");
    chk("n1_busy", busy, 1);
    chk("n1_addr", font_addr, 10'h180);
    chk("n1_valid", valid, 0);
    tick();
    chk("n2_valid", valid, 0);
    tick();
    chk("n3_valid", valid, 1);
    expect_frame("3210");
    wait_idle("f0123");
    chk("busy_fall_lat", idle_cyc, last_xfer_cyc + 1);
    chk("f0123_valid_after", valid, 0);
    if (mon_q.size() == 20) begin
      chk("first_addr", mon_q[0].addr, 10'h180);
      chk("last_addr", mon_q[19].addr, 10'h19C);
    end
    compare_stream("f0123");

    // Backpressure on byte 3
    t1 = rand_text();
    start_frame(t1);
    expect_frame(t1);
    n = 0;
    while (!(mon_q.size() == 2 && valid) && n < 100) begin
      tick();
      n++;
    end
    chk("bp_reach", 32'(mon_q.size() == 2 && valid), 1);
    ready  = 1'b0;
    hold_b = byte_o;
    hold_a = font_addr;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_valid_%0d", i), valid, 1);
      chk($sformatf("bp_byte_%0d", i), byte_o, hold_b);
      chk($sformatf("bp_addr_%0d", i), font_addr, hold_a);
    end
    ready = 1'b1;
    wait_idle("bp");
    compare_stream("bp");

    // Three requests while busy collapse into one extra frame using later text
    t1 = rand_text();
    start_frame(t1);
    expect_frame(t1);
    expect_frame("DCBA");
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      update = 1'b1;
      tick();
      update = 1'b0;
      tick();
    end
    text = "DCBA";
    n = 0;
    while (mon_q.size() < 40 && n < 3000) begin
      tick();
      n++;
    end
    wait_idle("pend");
    repeat (10) tick();
    chk("pend_no_third", busy, 0);
    compare_stream("pend");

    // Random frames under random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t1 = rand_text();
      start_frame(t1);
      expect_frame(t1);
      wait_idle($sformatf("rnd%0d", k));
      compare_stream($sformatf("rnd%0d", k));
    end
    rnd_ready = 1'b0;
    ready = 1'b1;

    // Reset during byte 7
    t1 = rand_text();
    start_frame(t1);
    n = 0;
    while (!(mon_q.size() == 6 && valid) && n < 200) begin
      tick();
      n++;
    end
    chk("mid_rst_reach", 32'(mon_q.size() == 6 && valid), 1);
    r_reset = 1'b1;
    ready = 1'b0;
    tick();
    r_reset = 1'b0;
    chk("mid_rst_valid", valid, 0);
`ifdef HCMS_POWERON_INIT_EN
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_disp", disp_rst, 1);
    mon_q.delete();
    ready = 1'b1;
    wait_idle("reinit");
    exp_q.push_back({10'h0, 8'h7F, 1'b1, 1'b1});
    exp_q.push_back({10'h0, 8'h81, 1'b1, 1'b1});
    compare_stream("reinit");
`else
    chk("mid_rst_busy", busy, 0);
    ready = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_more", mon_q.size(), 6);
    chk("mid_rst_idle", busy, 0);
    chk("no_ctrl_words", ctrl_seen, 0);
    mon_q.delete();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hcms_frame_loader.md
# hcms_frame_loader

Upstream feeder for the HCMS-29xx byte serializer. Holds a text frame of `NUM_CHARS` ASCII characters and expands each one through an external 5x7 font ROM into column bytes. Streams control words and dot-register bytes to the serializer over a valid/ready byte handshake. Flags group boundaries so the serializer can release chip-enable and latch.

## Interface

Parameters:

- `NUM_CHARS`, 4, number of characters in the display chain (5 column bytes each).
- `CTRL_WORD0`, 8'h7F, first control word sent at init.
- `CTRL_WORD1`, 8'h81, second control word sent at init.
- `RESET_CYCLES`, 16, number of cycles `o_display_reset` is held high during init.

Ports:

- `i_clk` in 1: clock.
- `r_reset` in 1: reset, synchronous, active-high; clock `i_clk`.
- `i_text` in 8*NUM_CHARS: ASCII frame; char 0 (leftmost) is `[7:0]`.
- `i_update` in 1: request a frame refresh; a level or a pulse is sampled each cycle.
- `o_busy` out 1: high while in any state other than IDLE.
- `o_font_addr` out 10: font ROM address `{char[6:0], col[2:0]}`, col 0..4.
- `i_font_data` in 8: ROM data; 1-cycle read latency; bit 7 is ignored.
- `o_byte` out 8: byte to the serializer.
- `o_byte_valid` out 1: `o_byte` is valid.
- `i_byte_ready` in 1: the serializer accepts. A transfer occurs when valid and ready are both high in the same cycle.
- `o_regsel` out 1: register select for the current byte; 1 = control, 0 = dot.
- `o_last` out 1: current byte ends its group; meaningful only while valid.
- `o_display_reset` out 1: display reset request, active-high.

## Operation

State machine states: RST_PULSE, CTRL0, CTRL1, IDLE, FETCH, ROMWAIT, SEND.

- RST_PULSE: `o_display_reset`=1 for `RESET_CYCLES` cycles, then go to CTRL0.
- CTRL0 and CTRL1: present the corresponding `CTRL_WORDn` with `o_regsel`=1 and `o_last`=1. Hold until the transfer completes, then advance: CTRL0 → CTRL1 → IDLE.
- IDLE: when `i_update`=1 or the pending flag is set:
  - capture `i_text` into an internal frame register;
  - clear the pending flag;
  - set the char and col indices to 0;
  - go to FETCH.
- FETCH: drive `o_font_addr` from the captured char and col, then go to ROMWAIT.
- ROMWAIT: register `{1'b0, i_font_data[6:0]}` into `o_byte`, then go to SEND.
- SEND: `o_byte_valid`=1 and `o_regsel`=0. `o_last`=1 only for char `NUM_CHARS-1`, col 4. On transfer:
  - if this was the last byte, go to IDLE;
  - otherwise increment col (wrapping 4→0 and incrementing char) and go to FETCH.
- Byte order is char 0 col 0 first, through char `NUM_CHARS-1` col 4: `NUM_CHARS*5` bytes per frame.
- Update while busy: `i_update`=1 in any non-IDLE state sets a single pending bit. Multiple requests collapse into one extra frame, which uses `i_text` as captured when that frame starts.
- `o_byte` and `o_regsel` are stable while `o_byte_valid`=1 and ready=0.
- The backpressure wait in SEND is unbounded.

Reset values (every output): `o_byte_valid`=0, `o_byte`=0, `o_regsel`=0, `o_last`=0, `o_font_addr`=0, pending=0. The remaining outputs depend on the macro:

- with `HCMS_POWERON_INIT_EN`: state=RST_PULSE, `o_display_reset`=1, `o_busy`=1;
- without it: state=IDLE, `o_display_reset`=0, `o_busy`=0.

Reset mid-operation: abandon the frame immediately and restart from the state given by the macro. `o_byte_valid` is 0 in the cycle after `r_reset` is sampled.

## Timing

- `i_update` sampled high in IDLE at cycle N:
  - N+1: `o_busy`=1, FETCH, `o_font_addr` valid.
  - N+2: ROMWAIT, ROM data registered.
  - N+3: `o_byte_valid`=1.
- Each dot byte costs 3 cycles plus handshake wait; the minimum frame is `NUM_CHARS*15` cycles.
- After the final transfer at cycle M: `o_byte_valid`=0 and `o_busy`=0 at M+1. If pending was set, FETCH starts at M+2.
- Control words: `o_byte_valid` rises in the first cycle of CTRL0. The CTRL1 word is valid in the cycle after the CTRL0 transfer.

## Configuration

Macro `HCMS_POWERON_INIT_EN`:

- Defined: after reset, the block runs RST_PULSE → CTRL0 → CTRL1 before reaching IDLE.
  - `i_update` during init sets pending, so the frame is sent right after CTRL1.
- Undefined: RST_PULSE, CTRL0 and CTRL1 are removed.
  - `o_display_reset` is tied to 0.
  - Reset goes directly to IDLE; the system controller is responsible for display configuration.

## Test plan

Bench font-ROM model: `data = {1'b1, addr[6:0]}`.

1. Macro on, `r_reset`=1 for 2 cycles → `o_display_reset`=1 for exactly 16 cycles, then 8'h7F and 8'h81, each with `o_regsel`=1 and `o_last`=1; then `o_busy`=0.
2. `i_text`="0123", `i_update` pulse, ready always 1 → 20 bytes with `o_regsel`=0.
   - First address 0x180, last address 0x19C.
   - Every byte has bit 7 = 0.
   - `o_last` high only on byte 20; `o_busy` falls 1 cycle after it.
3. Ready held 0 for 10 cycles on byte 3 → `o_byte` is unchanged and valid stays high for all 10 cycles; no address advance.
4. Three `i_update` pulses during a frame, then `i_text` changed to "ABCD" → exactly one extra frame, with addresses derived from 0x41..0x44.
5. `r_reset` asserted during byte 7 → `o_byte_valid`=0 the next cycle; init sequence restarts (macro on), or IDLE with `o_busy`=0 (macro off).
6. Macro off, reset released → `o_display_reset` stays 0. `i_update` at cycle N gives `o_byte_valid` at N+3, and no control words are ever emitted.
